// File: rtl/blackjack_table.sv
// Blackjack round controller: N_PLAYERS seats plus a dealer seat, cards fetched over request/ready,
// players choose hit/stand, the dealer draws to DEALER_STAND, then every player seat is scored.
module blackjack_table #(
  parameter int N_PLAYERS    = 2,
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 5,
  parameter int HAND_W       = 6,
  parameter int SEAT_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            begin_s,
  input  logic [3:0]                      cval,
  input  logic                            ready,
  input  logic                            opt,
  input  logic                            opt_valid,
  output logic                            request,
  output logic [SEAT_W-1:0]               seat,
  output logic [(N_PLAYERS+1)*HAND_W-1:0] hands,
  output logic [2*N_PLAYERS-1:0]          results,
  output logic                            end_s,
  output logic                            card_err,
  output logic [3:0]                      debug_state
);
  localparam int NS = N_PLAYERS + 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLEAR   = 4'd1,
    S_REQ     = 4'd2,
    S_WAIT    = 4'd3,
    S_ADD     = 4'd4,
    S_ADJUST  = 4'd5,
    S_ROUTE   = 4'd6,
    S_DECIDE  = 4'd7,
    S_RESOLVE = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    PH_DEAL   = 2'd0,
    PH_PLAY   = 2'd1,
    PH_DEALER = 2'd2
  } phase_t;

  state_t                 state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic [SEAT_W-1:0]      seat_q, seat_d;
  logic                   rnd_q, rnd_d;
  logic [3:0]             card_q, card_d;
  logic [HAND_W-1:0]      hand_q [NS];
  logic [HAND_W-1:0]      hand_d [NS];
  logic [3:0]             nr_q   [NS];
  logic [3:0]             nr_d   [NS];
  logic [3:0]             soft_q [NS];
  logic [3:0]             soft_d [NS];
  logic [2*N_PLAYERS-1:0] res_q, res_d;
  logic                   err_q, err_d;
  logic                   req_q, req_d;
  logic                   end_q, end_d;

  logic [HAND_W-1:0]      cur_hand;
  logic [3:0]             cur_nr;
  logic [3:0]             cur_soft;
  logic [HAND_W-1:0]      add_val;
  logic                   card_ace;
  logic                   cval_ok;
  logic                   seat_done;
  phase_t                 adv_phase;
  logic [SEAT_W-1:0]      adv_seat;

  function automatic logic [1:0] judge(input logic [HAND_W-1:0] h, input logic [HAND_W-1:0] d);
    logic [1:0] r;
    if (h > HAND_W'(TARGET))      r = 2'b10;
    else if (d > HAND_W'(TARGET)) r = 2'b01;
    else if (h > d)               r = 2'b01;
    else if (h < d)               r = 2'b10;
    else                          r = 2'b11;
    return r;
  endfunction

  // Select the active seat's data and decode the captured card.
  always_comb begin
    cur_hand = '0;
    cur_nr   = '0;
    cur_soft = '0;
    for (int i = 0; i < NS; i++) begin
      cur_hand = (seat_q == SEAT_W'(i)) ? hand_q[i] : cur_hand;
      cur_nr   = (seat_q == SEAT_W'(i)) ? nr_q[i]   : cur_nr;
      cur_soft = (seat_q == SEAT_W'(i)) ? soft_q[i] : cur_soft;
    end
    cval_ok   = (cval != 4'd0) && (cval < 4'd12);
    card_ace  = (card_q == 4'd1) || (card_q == 4'd11);
    add_val   = card_ace ? HAND_W'(11) : HAND_W'(card_q);
    seat_done = (cur_hand >= HAND_W'(TARGET)) || (cur_nr == 4'(MAX_CARDS));
  end

  // Where play goes once the current player stands or is finished.
  always_comb begin
    if (seat_q == SEAT_W'(N_PLAYERS - 1)) begin
      adv_phase = PH_DEALER;
      adv_seat  = SEAT_W'(N_PLAYERS);
    end else begin
      adv_phase = PH_PLAY;
      adv_seat  = seat_q + 1'b1;
    end
  end

  // Round sequencing and seat datapath next-state.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    seat_d  = seat_q;
    rnd_d   = rnd_q;
    card_d  = card_q;
    hand_d  = hand_q;
    nr_d    = nr_q;
    soft_d  = soft_q;
    res_d   = res_q;
    err_d   = err_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = begin_s ? S_CLEAR : state_q;
      end
      S_CLEAR: begin
        hand_d  = '{default: '0};
        nr_d    = '{default: '0};
        soft_d  = '{default: '0};
        res_d   = '0;
        err_d   = 1'b0;
        seat_d  = '0;
        rnd_d   = 1'b0;
        phase_d = PH_DEAL;
        state_d = S_REQ;
      end
      S_REQ: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ready) begin
          card_d  = cval;
          req_d   = 1'b0;
          err_d   = cval_ok ? err_q : 1'b1;
          state_d = cval_ok ? S_ADD : S_REQ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ADD: begin
        for (int i = 0; i < NS; i++) begin
          if (seat_q == SEAT_W'(i)) begin
            hand_d[i] = hand_q[i] + add_val;
            soft_d[i] = card_ace ? soft_q[i] + 4'd1 : soft_q[i];
            nr_d[i]   = (nr_q[i] == 4'd15) ? nr_q[i] : nr_q[i] + 4'd1;
          end else begin
            hand_d[i] = hand_q[i];
          end
        end
        state_d = S_ADJUST;
      end
      S_ADJUST: begin
        // One soft ace is demoted from 11 to 1 per cycle while the hand is over the limit.
        if ((cur_hand > HAND_W'(TARGET)) && (cur_soft != 4'd0)) begin
          for (int i = 0; i < NS; i++) begin
            hand_d[i] = (seat_q == SEAT_W'(i)) ? hand_q[i] - HAND_W'(10) : hand_q[i];
            soft_d[i] = (seat_q == SEAT_W'(i)) ? soft_q[i] - 4'd1 : soft_q[i];
          end
          state_d = S_ADJUST;
        end else begin
          state_d = S_ROUTE;
        end
      end
      S_ROUTE: begin
        case (phase_q)
          PH_DEAL: begin
            if (seat_q == SEAT_W'(N_PLAYERS)) begin
              seat_d  = '0;
              rnd_d   = 1'b1;
              phase_d = rnd_q ? PH_PLAY : PH_DEAL;
              state_d = rnd_q ? S_ROUTE : S_REQ;
            end else begin
              seat_d  = seat_q + 1'b1;
              state_d = S_REQ;
            end
          end
          PH_PLAY: begin
            if (seat_done) begin
              phase_d = adv_phase;
              seat_d  = adv_seat;
              state_d = S_ROUTE;
            end else begin
              state_d = S_DECIDE;
            end
          end
          PH_DEALER: begin
            if ((cur_hand < HAND_W'(DEALER_STAND)) && (cur_nr < 4'(MAX_CARDS))) begin
              state_d = S_REQ;
            end else begin
              state_d = S_RESOLVE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_DECIDE: begin
        if (opt_valid && opt) begin
          phase_d = adv_phase;
          seat_d  = adv_seat;
          state_d = S_ROUTE;
        end else if (opt_valid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DECIDE;
        end
      end
      S_RESOLVE: begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          res_d[2*p +: 2] = judge(hand_q[p], hand_q[N_PLAYERS]);
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    end_d = (state_d == S_DONE);
  end

  // State and seat data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_DEAL;
      seat_q  <= '0;
      rnd_q   <= 1'b0;
      card_q  <= 4'd0;
      hand_q  <= '{default: '0};
      nr_q    <= '{default: '0};
      soft_q  <= '{default: '0};
      res_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      seat_q  <= seat_d;
      rnd_q   <= rnd_d;
      card_q  <= card_d;
      hand_q  <= hand_d;
      nr_q    <= nr_d;
      soft_q  <= soft_d;
      res_q   <= res_d;
      err_q   <= err_d;
      req_q   <= req_d;
      end_q   <= end_d;
    end
  end

  // Pack seat totals onto the display bus.
  always_comb begin
    hands = '0;
    for (int i = 0; i < NS; i++) begin
      hands[i*HAND_W +: HAND_W] = hand_q[i];
    end
  end

  assign request     = req_q;
  assign seat        = seat_q;
  assign results     = res_q;
  assign end_s       = end_q;
  assign card_err    = err_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_blackjack_table.sv
// Scoreboarded bench for blackjack_table: a card-level model plays each round up front and queues
// the card/seat/decision streams and the final table; a monitor compares what the DUT presents.
module tb_blackjack_table;
  localparam int NP = 2;
  localparam int NS = NP + 1;
  localparam int HW = 6;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              begin_s = 1'b0;
  logic [3:0]        cval = 4'd0;
  logic              ready = 1'b0;
  logic              opt = 1'b0;
  logic              opt_valid = 1'b0;
  logic              request;
  logic [SW-1:0]     seat;
  logic [NS*HW-1:0]  hands;
  logic [2*NP-1:0]   results;
  logic              end_s;
  logic              card_err;
  logic [3:0]        debug_state;

  always #5 clk = ~clk;

  blackjack_table #(.N_PLAYERS(NP), .TARGET(21), .DEALER_STAND(17), .MAX_CARDS(5),
                    .HAND_W(HW), .SEAT_W(SW)) dut (
    .clk(clk), .rst(rst), .begin_s(begin_s), .cval(cval), .ready(ready), .opt(opt),
    .opt_valid(opt_valid), .request(request), .seat(seat), .hands(hands), .results(results),
    .end_s(end_s), .card_err(card_err), .debug_state(debug_state));

  typedef struct {
    logic [NS*HW-1:0] hands;
    logic [2*NP-1:0]  res;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   card_q[$];
  int   seat_exp_q[$];
  bit   opt_q[$];
  int   forced_q[$];
  int   thr[NP];
  int   m_hand[NS];
  int   m_soft[NS];
  int   m_n[NS];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  function automatic int draw();
    int v;
    if (forced_q.size() > 0) v = forced_q.pop_front();
    else v = $urandom_range(1, 11);
    return v;
  endfunction

  // Blackjack scoring: aces count 11, dropping to 1 while the hand is over 21.
  function automatic void take(input int s, input int v);
    if (v == 1 || v == 11) begin
      m_hand[s] += 11;
      m_soft[s]++;
    end else begin
      m_hand[s] += v;
    end
    m_n[s]++;
    while (m_hand[s] > 21 && m_soft[s] > 0) begin
      m_hand[s] -= 10;
      m_soft[s]--;
    end
  endfunction

  function automatic void deal_card(input int s);
    int v;
    v = draw();
    card_q.push_back(v);
    seat_exp_q.push_back(s);
    take(s, v);
  endfunction

  function automatic void model_round(input bit err);
    exp_t e;
    int   r;
    for (int s = 0; s < NS; s++) begin
      m_hand[s] = 0; m_soft[s] = 0; m_n[s] = 0;
    end
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NS; s++) deal_card(s);
    for (int p = 0; p < NP; p++) begin
      while (m_hand[p] < 21 && m_n[p] < 5) begin
        if (m_hand[p] >= thr[p]) begin
          opt_q.push_back(1'b1);
          break;
        end
        opt_q.push_back(1'b0);
        deal_card(p);
      end
    end
    while (m_hand[NP] < 17 && m_n[NP] < 5) deal_card(NP);
    e.hands = '0;
    e.res   = '0;
    for (int s = 0; s < NS; s++) e.hands[s*HW +: HW] = HW'(m_hand[s]);
    for (int p = 0; p < NP; p++) begin
      if (m_hand[p] > 21)             r = 2;
      else if (m_hand[NP] > 21)       r = 1;
      else if (m_hand[p] > m_hand[NP]) r = 1;
      else if (m_hand[p] < m_hand[NP]) r = 2;
      else                            r = 3;
      e.res[2*p +: 2] = 2'(r);
    end
    e.err = err;
    exp_q.push_back(e);
  endfunction

  // Monitor: checks the seat of every fresh card request and the table at each round end.
  initial begin
    logic req_prev = 1'b0;
    logic end_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (request && !req_prev) begin
        if (seat_exp_q.size() == 0) fail("unexpected_request");
        else chk("request_seat", 64'(seat), 64'(seat_exp_q[0]));
      end
      if (end_s && !end_prev) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_round_end");
        end else begin
          e = exp_q.pop_front();
          chk("hands", 64'(hands), 64'(e.hands));
          chk("results", 64'(results), 64'(e.res));
          chk("card_err", 64'(card_err), 64'(e.err));
        end
      end
      req_prev = request;
      end_prev = end_s;
    end
  end

  // Driver: plays one round, serving cards and decisions from the model's queues.
  task automatic run_round(input int inj_idx, input int bad_val);
    int            cyc = 0;
    int            idx = 0;
    int            inj_cyc = -10;
    bit            injected = 1'b0;
    bit            done = 1'b0;
    logic [SW-1:0] inj_seat = '0;
    int            bads[5] = '{0, 12, 13, 14, 15};
    model_round(inj_idx >= 0);
    @(negedge clk) begin_s = 1'b1;
    @(negedge clk) begin_s = 1'b0;
    while (!done) begin
      @(negedge clk);
      ready     = 1'b0;
      opt_valid = 1'b0;
      cval      = 4'($urandom);
      opt       = 1'($urandom);
      cyc++;
      if (cyc == 1) begin
        chk("clear_hands", 64'(hands), 64'(0));
        chk("clear_results", 64'(results), 64'(0));
        chk("clear_card_err", 64'(card_err), 64'(0));
      end
      if (cyc == inj_cyc + 1) chk("err_sticky", 64'(card_err), 64'(1));
      if (cyc == inj_cyc + 2) begin
        chk("rerequest", 64'(request), 64'(1));
        chk("rerequest_seat", 64'(seat), 64'(inj_seat));
      end
      if (end_s) begin
        done = 1'b1;
      end else if (cyc > 3000) begin
        fail("round_timeout");
        done = 1'b1;
      end else if (request) begin
        if ($urandom_range(0, 2) != 0) begin
          ready = 1'b1;
          if (!injected && idx == inj_idx) begin
            cval     = (bad_val >= 0) ? 4'(bad_val) : 4'(bads[$urandom_range(0, 4)]);
            injected = 1'b1;
            inj_cyc  = cyc;
            inj_seat = seat;
          end else if (card_q.size() == 0) begin
            fail("extra_card_request");
            cval = 4'd2;
          end else begin
            cval = 4'(card_q.pop_front());
            void'(seat_exp_q.pop_front());
            idx++;
          end
        end
      end else if (debug_state == 4'd7) begin
        if ($urandom_range(0, 1) != 0) begin
          opt_valid = 1'b1;
          if (opt_q.size() == 0) begin
            fail("unexpected_decision");
            opt = 1'b1;
          end else begin
            opt = opt_q.pop_front();
          end
        end
      end else begin
        ready     = ($urandom_range(0, 3) == 0);
        opt_valid = ($urandom_range(0, 3) == 0);
      end
    end
    ready     = 1'b0;
    opt_valid = 1'b0;
    chk("cards_left", 64'(card_q.size()), 64'(0));
    chk("decisions_left", 64'(opt_q.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_request", 64'(request), 64'(0));
    chk("rst_state", 64'(debug_state), 64'(0));
    chk("rst_hands", 64'(hands), 64'(0));
    chk("rst_results", 64'(results), 64'(0));
    chk("rst_end", 64'(end_s), 64'(0));
    chk("rst_err", 64'(card_err), 64'(0));
    @(negedge clk) rst = 1'b1;

    forced_q = '{10, 9, 10, 7, 9, 6, 5};
    thr[0] = 0; thr[1] = 0;
    run_round(-1, -1);
    chk("dealer21_results", 64'(results), 64'(4'b1010));

    forced_q = '{1, 10, 10, 11, 8, 7, 9};
    thr[0] = 20; thr[1] = 0;
    run_round(-1, -1);
    chk("ace_hand", 64'(hands[HW-1:0]), 64'(21));

    forced_q = '{10, 10, 10, 8, 8, 6, 6, 10};
    thr[0] = 19; thr[1] = 0;
    run_round(-1, -1);
    chk("bust_results", 64'(results), 64'(4'b0110));

    forced_q = '{10, 10, 10, 7, 8, 8};
    thr[0] = 0; thr[1] = 0;
    run_round(-1, -1);
    chk("push_results", 64'(results), 64'(4'b1110));

    thr[0] = 15; thr[1] = 17;
    run_round(0, 13);
    run_round(-1, -1);

    for (int r = 0; r < 40; r++) begin
      thr[0] = $urandom_range(12, 21);
      thr[1] = $urandom_range(12, 21);
      run_round(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1);
    end

    model_round(1'b0);
    @(negedge clk) begin_s = 1'b1;
    @(negedge clk) begin_s = 1'b0;
    for (int c = 0; c < 20 && !request; c++) @(negedge clk);
    if (!request) fail("wait_request_timeout");
    #2 rst = 1'b0;
    #1;
    chk("midrst_request", 64'(request), 64'(0));
    chk("midrst_state", 64'(debug_state), 64'(0));
    chk("midrst_hands", 64'(hands), 64'(0));
    card_q.delete();
    seat_exp_q.delete();
    opt_q.delete();
    exp_q.delete();
    @(negedge clk) rst = 1'b1;

    thr[0] = 16; thr[1] = 14;
    run_round(-1, -1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blackjack_table.md
Name: blackjack_table

Overview:
- Parametrised multi-seat blackjack round controller: N_PLAYERS player hands plus one dealer hand.
- Deals, runs each player's hit/stand turn, plays the dealer to a stand threshold, then resolves win/lose/push per player.
- Cards arrive over a request/ready handshake from the card source. Hand totals and results go to the LCD/7-segment drivers.
- Restartable: a new round starts from DONE without reset.

Parameters:
- N_PLAYERS, 2, player seats (1..7); dealer is seat index N_PLAYERS.
- TARGET, 21, bust limit / blackjack score.
- DEALER_STAND, 17, dealer draws while hand < DEALER_STAND.
- MAX_CARDS, 5, seat auto-stands once it holds MAX_CARDS cards.
- HAND_W, 6, hand register width (must hold TARGET+11).
- SEAT_W, 3, width of seat index (>= clog2(N_PLAYERS+1)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- begin_s  in  1  start round; honoured only in IDLE or DONE.
- cval  in  4  card value: 2..10 face; 1 or 11 = ace; others invalid.
- ready  in  1  card source: cval valid this cycle.
- opt  in  1  current player's choice: 1 = stand, 0 = hit.
- opt_valid  in  1  opt qualifier.
- request  out  1  card request, registered.
- seat  out  SEAT_W  seat the requested/decided card belongs to.
- hands  out  (N_PLAYERS+1)*HAND_W  seat i total at bits [i*HAND_W +: HAND_W].
- results  out  2*N_PLAYERS  per player: 00 pending, 01 win, 10 lose, 11 push.
- end_s  out  1  high in DONE.
- card_err  out  1  sticky: invalid cval seen this round.
- debug_state  out  4  state encoding.

Behaviour:
- Reset (async, rst=0): state IDLE; request=0, seat=0, all hands/nr_cards/soft_aces=0, results=0, end_s=0, card_err=0. Applies mid-handshake; request drops immediately.
- States: IDLE=0, CLEAR=1, REQ=2, WAIT=3, ADD=4, ADJUST=5, ROUTE=6, DECIDE=7, RESOLVE=8, DONE=9. Phase register: DEAL / PLAY / DEALER.
- IDLE/DONE + begin_s -> CLEAR. CLEAR zeroes all seat data, results, card_err; sets seat=0, phase=DEAL; -> REQ.
- REQ: request<=1 -> WAIT.
- WAIT: hold until ready. On ready, capture cval, request<=0.
  - Invalid value (0, 12..15): card_err<=1, -> REQ (re-request, same seat).
  - Valid value: -> ADD.
  - ready outside WAIT is ignored.
- ADD: hand+=value (ace adds 11, soft_aces+=1); nr_cards+=1 (saturating at 15) -> ADJUST.
- ADJUST: while hand>TARGET and soft_aces>0, subtract 10 and decrement soft_aces, one per cycle. Then -> ROUTE.
- ROUTE by phase:
  - DEAL: round-robin seat 0..N_PLAYERS, twice (2*(N_PLAYERS+1) cards). After the last card: phase=PLAY, seat=0.
  - PLAY: player done if hand>=TARGET or nr_cards==MAX_CARDS, else -> DECIDE. Done -> next seat; after the last player: phase=DEALER, seat=N_PLAYERS.
  - DEALER: hand<DEALER_STAND and nr_cards<MAX_CARDS -> REQ, else -> RESOLVE.
- DECIDE: wait for opt_valid. opt=0 -> REQ; opt=1 -> advance seat as in ROUTE. opt_valid outside DECIDE is ignored.
- RESOLVE (1 cycle): per player p, with dealer hand d and player hand h:
  - h>TARGET -> lose.
  - else d>TARGET -> win.
  - else h>d win, h<d lose, h==d push.
  - -> DONE.
- DONE: end_s=1; hands/results held until begin_s. begin_s in any other state is ignored.
- Latency per card, excluding the ready wait: REQ 1 + WAIT 1 + ADD 1 + ADJUST (1 + reductions) + ROUTE 1.

Test Plan:
- N_PLAYERS=2. Deal 10,7 | 9,9 | 10,6; player0 stands, player1 stands; dealer draws 5 -> dealer 21. Required: results = p0 10 (lose), p1 10 (lose); end_s=1.
- Player0 dealt ace,ace -> hand 12, soft_aces=1 after one ADJUST cycle. Hit 9 -> 21, auto-stands with no DECIDE visit.
- Player hits 10,8 then 6 -> 24, no soft ace. Required: bust; dealer still plays; that player's result = 10 (lose) even if dealer busts.
- Dealer 10,6 draws 10 -> 26. Non-bust players: 01 (win). Player and dealer both 18: 11 (push).
- cval=13 on ready -> card_err=1, request re-asserted next-but-one cycle, same seat. Reset asserted in WAIT -> request=0 immediately, state IDLE.
- From DONE, begin_s=1 -> CLEAR clears hands, results and card_err; the new round deals from seat 0.
